// File: rtl/ysyx_23060201_mem_arbiter_pkg.sv
// Shared encodings for the fetch/LSU memory arbiter.
// State, owner and memory-base definitions.
package ysyx_23060201_mem_arbiter_pkg;

  localparam logic [31:0] MBASE_DEFAULT = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MREQ    = 2'd1,
    MRSP    = 2'd2,
    DELIVER = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

endpackage

// File: rtl/ysyx_23060201_arb_grant.sv
// Combinational grant between fetch and load/store.
// ARB_ROUND_ROBIN_EN: alternate on contention, else LSU first.
module ysyx_23060201_arb_grant
  import ysyx_23060201_mem_arbiter_pkg::*;
(
  input  logic   if_valid,
  input  logic   ls_valid,
`ifdef ARB_ROUND_ROBIN_EN
  input  owner_e last_owner,
`endif
  output logic   grant_if,
  output logic   grant_ls
);

  // pick exactly one requester; contention resolved by policy
  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    unique case (1'b1)
      (if_valid && ls_valid): begin
`ifdef ARB_ROUND_ROBIN_EN
        grant_ls = (last_owner == OWN_IF);
        grant_if = (last_owner == OWN_LS);
`else
        grant_ls = 1'b1;
`endif
      end
      (ls_valid && !if_valid): grant_ls = 1'b1;
      (if_valid && !ls_valid): grant_if = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_23060201_mem_arbiter.sv
// Fetch/LSU arbiter onto one memory port, one outstanding op.
// ARB_ROUND_ROBIN_EN selects round-robin grant on contention.
module ysyx_23060201_mem_arbiter
  import ysyx_23060201_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MASK_W = 8,
  parameter logic [ADDR_W-1:0] MBASE = ADDR_W'(MBASE_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rsp_valid,
  input  logic              if_rsp_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic              ls_wen,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [MASK_W-1:0] ls_wmask,
  output logic              ls_rsp_valid,
  input  logic              ls_rsp_ready,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_rsp_valid,
  output logic              mem_rsp_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e state;
  owner_e owner;
  logic   idle_q;
  logic   grant_if;
  logic   grant_ls;
  logic   if_acc;
  logic   ls_acc;
  logic   acc;
  logic   acc_wen;
  logic   local_hit;
  logic   rsp_hs;
  logic [ADDR_W-1:0] acc_addr;

`ifdef ARB_ROUND_ROBIN_EN
  owner_e last_owner;
`endif

  ysyx_23060201_arb_grant u_grant (
    .if_valid   (if_req_valid),
    .ls_valid   (ls_req_valid),
`ifdef ARB_ROUND_ROBIN_EN
    .last_owner (last_owner),
`endif
    .grant_if   (grant_if),
    .grant_ls   (grant_ls)
  );

  // idle_q is a registered IDLE flag so ready is low in reset
  assign if_req_ready = idle_q && grant_if;
  assign ls_req_ready = idle_q && grant_ls;
  assign if_acc    = if_req_valid && if_req_ready;
  assign ls_acc    = ls_req_valid && ls_req_ready;
  assign acc       = if_acc || ls_acc;
  assign acc_addr  = ls_acc ? ls_addr : if_addr;
  assign acc_wen   = ls_acc && ls_wen;
  assign local_hit = (acc_addr < MBASE);
  assign rsp_hs    = (owner == OWN_LS)
                   ? (ls_rsp_valid && ls_rsp_ready)
                   : (if_rsp_valid && if_rsp_ready);

  // transaction FSM with registered handshake outputs and buffers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      owner         <= OWN_IF;
      idle_q        <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_rsp_ready <= 1'b0;
      if_rsp_valid  <= 1'b0;
      ls_rsp_valid  <= 1'b0;
      mem_addr      <= '0;
      mem_wen       <= 1'b0;
      mem_wdata     <= '0;
      mem_wmask     <= '0;
      if_rdata      <= '0;
      ls_rdata      <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner    <= OWN_IF;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (acc) begin
            idle_q    <= 1'b0;
            owner     <= ls_acc ? OWN_LS : OWN_IF;
            mem_addr  <= acc_addr;
            mem_wen   <= acc_wen;
            mem_wdata <= acc_wen ? ls_wdata : '0;
            mem_wmask <= acc_wen ? ls_wmask : '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner <= ls_acc ? OWN_LS : OWN_IF;
`endif
            if (local_hit) begin
              state <= DELIVER;
              if (ls_acc) begin
                ls_rsp_valid <= 1'b1;
                ls_rdata     <= '0;
              end else begin
                if_rsp_valid <= 1'b1;
                if_rdata     <= '0;
              end
            end else begin
              state         <= MREQ;
              mem_req_valid <= 1'b1;
            end
          end else begin
            idle_q <= 1'b1;
          end
        end
        MREQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            mem_rsp_ready <= 1'b1;
            state         <= MRSP;
          end
        end
        MRSP: begin
          if (mem_rsp_valid) begin
            mem_rsp_ready <= 1'b0;
            state         <= DELIVER;
            if (owner == OWN_LS) begin
              ls_rsp_valid <= 1'b1;
              ls_rdata     <= mem_wen ? '0 : mem_rdata;
            end else begin
              if_rsp_valid <= 1'b1;
              if_rdata     <= mem_rdata;
            end
          end
        end
        DELIVER: begin
          if (rsp_hs) begin
            if_rsp_valid <= 1'b0;
            ls_rsp_valid <= 1'b0;
            idle_q       <= 1'b1;
            state        <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060201_mem_arbiter.sv
// Directed bench for ysyx_23060201_mem_arbiter.
// Inputs change on negedge, outputs sampled 1ns later.
module tb_ysyx_23060201_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req_valid, ls_req_ready, ls_wen, ls_rsp_valid, ls_rsp_ready;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [7:0]  ls_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen;
  logic        mem_rsp_valid, mem_rsp_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  int checks = 0;
  int failures = 0;
  int n_mreq = 0;
  int n_mrsp = 0;
  int n_ifrsp = 0;

  always #5 clk = ~clk;

  ysyx_23060201_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
    .if_addr(if_addr), .if_rsp_valid(if_rsp_valid),
    .if_rsp_ready(if_rsp_ready), .if_rdata(if_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready),
    .ls_addr(ls_addr), .ls_wen(ls_wen), .ls_wdata(ls_wdata),
    .ls_wmask(ls_wmask), .ls_rsp_valid(ls_rsp_valid),
    .ls_rsp_ready(ls_rsp_ready), .ls_rdata(ls_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_ready(mem_rsp_ready), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_req_valid && mem_req_ready) n_mreq++;
    if (mem_rsp_valid && mem_rsp_ready) n_mrsp++;
    if (if_rsp_valid && if_rsp_ready) n_ifrsp++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid,
         mem_req_valid, mem_rsp_ready} !== 6'b0) begin
      failures++;
      $display("FAIL reset_hs got=%b exp=000000",
        {if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid,
         mem_req_valid, mem_rsp_ready});
    end
    checks++;
    if ({mem_addr, mem_wdata, mem_wmask, mem_wen, if_rdata, ls_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_data addr=%h wdata=%h mask=%h wen=%b ifd=%h lsd=%h exp=0",
        mem_addr, mem_wdata, mem_wmask, mem_wen, if_rdata, ls_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid,
         mem_req_valid, mem_rsp_ready} !== 6'b0) begin
      failures++;
      $display("FAIL post_reset_idle got=%b exp=000000",
        {if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid,
         mem_req_valid, mem_rsp_ready});
    end
  endtask

  task automatic test_fetch_read();
    @(negedge clk);
    if_req_valid = 1'b1;
    if_addr = 32'h8000_0000;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rdata = 32'h0000_0413;
    #1;
    checks++;
    if ({if_req_ready, ls_req_ready} !== 2'b10) begin
      failures++;
      $display("FAIL fetch_grant got=%b exp=10", {if_req_ready, ls_req_ready});
    end
    @(negedge clk);
    if_req_valid = 1'b0;
    if_addr = '0;
    #1;
    checks++;
    if ({mem_req_valid, mem_rsp_ready, mem_wen, mem_wmask, mem_addr} !==
        {1'b1, 1'b0, 1'b0, 8'h00, 32'h8000_0000}) begin
      failures++;
      $display("FAIL fetch_mreq v=%b rr=%b wen=%b mask=%h addr=%h exp 1 0 0 00 80000000",
        mem_req_valid, mem_rsp_ready, mem_wen, mem_wmask, mem_addr);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({mem_req_valid, mem_rsp_ready, if_rsp_valid} !== 3'b010) begin
      failures++;
      $display("FAIL fetch_mrsp got=%b exp=010",
        {mem_req_valid, mem_rsp_ready, if_rsp_valid});
    end
    @(negedge clk);
    #1;
    checks++;
    if ({if_rsp_valid, ls_rsp_valid} !== 2'b10 || if_rdata !== 32'h0000_0413) begin
      failures++;
      $display("FAIL fetch_deliver v=%b%b rdata=%h exp 10 00000413",
        if_rsp_valid, ls_rsp_valid, if_rdata);
    end
    if_rsp_ready = 1'b1;
    @(negedge clk);
    if_rsp_ready = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    #1;
    checks++;
    if ({if_rsp_valid, ls_rsp_valid, mem_req_valid, mem_rsp_ready} !== 4'b0) begin
      failures++;
      $display("FAIL fetch_idle got=%b exp=0000",
        {if_rsp_valid, ls_rsp_valid, mem_req_valid, mem_rsp_ready});
    end
  endtask

  task automatic test_contention_write();
    @(negedge clk);
    if_req_valid = 1'b1;
    if_addr = 32'h8000_0004;
    ls_req_valid = 1'b1;
    ls_addr = 32'h8000_0010;
    ls_wen = 1'b1;
    ls_wdata = 32'hDEAD_BEEF;
    ls_wmask = 8'b0000_1111;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rdata = 32'h1234_5678;
    #1;
    checks++;
    if ({if_req_ready, ls_req_ready} !== 2'b01) begin
      failures++;
      $display("FAIL contend_grant got=%b exp=01", {if_req_ready, ls_req_ready});
    end
    @(negedge clk);
    ls_req_valid = 1'b0;
    ls_wen = 1'b0;
    #1;
    checks++;
    if ({if_req_ready, mem_req_valid, mem_wen, mem_wmask, mem_addr, mem_wdata} !==
        {1'b0, 1'b1, 1'b1, 8'h0F, 32'h8000_0010, 32'hDEAD_BEEF}) begin
      failures++;
      $display("FAIL write_mreq rdy=%b v=%b wen=%b mask=%h addr=%h wd=%h exp 0 1 1 0f 80000010 deadbeef",
        if_req_ready, mem_req_valid, mem_wen, mem_wmask, mem_addr, mem_wdata);
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if ({ls_rsp_valid, if_rsp_valid, if_req_ready} !== 3'b100 || ls_rdata !== 32'h0) begin
      failures++;
      $display("FAIL write_deliver lsv=%b ifv=%b ifrdy=%b rdata=%h exp 1 0 0 00000000",
        ls_rsp_valid, if_rsp_valid, if_req_ready, ls_rdata);
    end
    ls_rsp_ready = 1'b1;
    @(negedge clk);
    ls_rsp_ready = 1'b0;
    mem_rdata = 32'hCAFE_0001;
    #1;
    checks++;
    if ({if_req_ready, ls_rsp_valid} !== 2'b10) begin
      failures++;
      $display("FAIL fetch_after_ls got=%b exp=10", {if_req_ready, ls_rsp_valid});
    end
    @(negedge clk);
    if_req_valid = 1'b0;
    #1;
    checks++;
    if ({mem_req_valid, mem_wen, mem_wmask, mem_addr} !==
        {1'b1, 1'b0, 8'h00, 32'h8000_0004}) begin
      failures++;
      $display("FAIL read_mreq v=%b wen=%b mask=%h addr=%h exp 1 0 00 80000004",
        mem_req_valid, mem_wen, mem_wmask, mem_addr);
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (if_rsp_valid !== 1'b1 || if_rdata !== 32'hCAFE_0001 || ls_rdata !== 32'h0) begin
      failures++;
      $display("FAIL fetch2_deliver v=%b rdata=%h lsd=%h exp 1 cafe0001 0",
        if_rsp_valid, if_rdata, ls_rdata);
    end
    if_rsp_ready = 1'b1;
    @(negedge clk);
    if_rsp_ready = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
  endtask

  task automatic test_local();
    int a0;
    a0 = n_mreq;
    @(negedge clk);
    if_req_valid = 1'b1;
    if_addr = 32'h0000_0100;
    mem_req_ready = 1'b1;
    #1;
    checks++;
    if (if_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL local_grant got=%b exp=1", if_req_ready);
    end
    @(negedge clk);
    if_req_valid = 1'b0;
    #1;
    checks++;
    if ({if_rsp_valid, mem_req_valid} !== 2'b10 || if_rdata !== 32'h0) begin
      failures++;
      $display("FAIL local_deliver v=%b mreq=%b rdata=%h exp 1 0 00000000",
        if_rsp_valid, mem_req_valid, if_rdata);
    end
    if_rsp_ready = 1'b1;
    @(negedge clk);
    if_rsp_ready = 1'b0;
    mem_req_ready = 1'b0;
    #1;
    checks++;
    if (n_mreq - a0 !== 0 || if_rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL local_nomem mreqs=%0d v=%b exp 0 0", n_mreq - a0, if_rsp_valid);
    end
  endtask

  task automatic test_backpressure();
    int a0, b0, c0;
    a0 = n_mreq;
    b0 = n_mrsp;
    c0 = n_ifrsp;
    @(negedge clk);
    if_req_valid = 1'b1;
    if_addr = 32'h8000_0020;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if_req_valid = 1'b0;
      #1;
      checks++;
      if ({mem_req_valid, mem_wmask, mem_addr} !== {1'b1, 8'h00, 32'h8000_0020}) begin
        failures++;
        $display("FAIL bp_mreq_hold cyc=%0d v=%b mask=%h addr=%h exp 1 00 80000020",
          i, mem_req_valid, mem_wmask, mem_addr);
      end
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({mem_rsp_ready, mem_req_valid} !== 2'b10 || mem_addr !== 32'h8000_0020) begin
        failures++;
        $display("FAIL bp_mrsp_wait cyc=%0d rr=%b v=%b addr=%h exp 1 0 80000020",
          i, mem_rsp_ready, mem_req_valid, mem_addr);
      end
      @(negedge clk);
    end
    mem_rsp_valid = 1'b1;
    mem_rdata = 32'h55AA_1234;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    mem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (if_rsp_valid !== 1'b1 || if_rdata !== 32'h55AA_1234) begin
        failures++;
        $display("FAIL bp_rdata_hold cyc=%0d v=%b rdata=%h exp 1 55aa1234",
          i, if_rsp_valid, if_rdata);
      end
      if (i == 2) if_rsp_ready = 1'b1;
      @(negedge clk);
    end
    if_rsp_ready = 1'b0;
    #1;
    checks++;
    if ({n_mreq - a0, n_mrsp - b0, n_ifrsp - c0} !== {32'd1, 32'd1, 32'd1}) begin
      failures++;
      $display("FAIL bp_handshakes req=%0d rsp=%0d ifrsp=%0d exp 1 1 1",
        n_mreq - a0, n_mrsp - b0, n_ifrsp - c0);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    if_req_valid = 1'b1;
    if_addr = 32'h8000_0040;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    if_req_valid = 1'b0;
    @(negedge clk);
    mem_req_ready = 1'b0;
    #1;
    checks++;
    if (mem_rsp_ready !== 1'b1) begin
      failures++;
      $display("FAIL rmid_in_mrsp rr=%b exp 1", mem_rsp_ready);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_rsp_ready, mem_req_valid, if_rsp_valid, ls_rsp_valid,
         if_req_ready, ls_req_ready} !== 6'b0 || mem_addr !== 32'h0) begin
      failures++;
      $display("FAIL rmid_async got=%b addr=%h exp 000000 0",
        {mem_rsp_ready, mem_req_valid, if_rsp_valid, ls_rsp_valid,
         if_req_ready, ls_req_ready}, mem_addr);
    end
    mem_rsp_valid = 1'b1;
    mem_rdata = 32'h1111_1111;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({if_rsp_valid, ls_rsp_valid, mem_rsp_ready, mem_req_valid} !== 4'b0) begin
        failures++;
        $display("FAIL rmid_stale cyc=%0d got=%b exp 0000", i,
          {if_rsp_valid, ls_rsp_valid, mem_rsp_ready, mem_req_valid});
      end
    end
    mem_rsp_valid = 1'b0;
  endtask

  task automatic test_grant_policy();
    logic [1:0] exp_g;
    logic       got;
    int         n;
    if_req_valid = 1'b1;
    if_addr = 32'h0000_0010;
    ls_req_valid = 1'b1;
    ls_addr = 32'h0000_0020;
    ls_wen = 1'b0;
    if_rsp_ready = 1'b1;
    ls_rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      got = 1'b0;
      n = 0;
      while (!got && n < 6) begin
        @(negedge clk);
        #1;
        if (if_req_ready || ls_req_ready) got = 1'b1;
        n++;
      end
`ifdef ARB_ROUND_ROBIN_EN
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b01;
`endif
      checks++;
      if (!got) begin
        failures++;
        $display("FAIL grant_timeout txn=%0d no grant in 6 cycles", i);
      end else if ({if_req_ready, ls_req_ready} !== exp_g) begin
        failures++;
        $display("FAIL grant_order txn=%0d got=%b exp=%b", i,
          {if_req_ready, ls_req_ready}, exp_g);
      end
    end
    @(negedge clk);
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    if_rsp_ready = 1'b0;
    ls_rsp_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    if_req_valid = 1'b0;
    if_addr = '0;
    if_rsp_ready = 1'b0;
    ls_req_valid = 1'b0;
    ls_addr = '0;
    ls_wen = 1'b0;
    ls_wdata = '0;
    ls_wmask = '0;
    ls_rsp_ready = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rdata = '0;
    test_reset();
    test_fetch_read();
    test_contention_write();
    test_local();
    test_backpressure();
    test_reset_mid();
    test_grant_policy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_23060201_mem_arbiter.md
Name: ysyx_23060201_mem_arbiter

Overview:
Shares the single physical memory port between instruction fetch (read-only) and load/store (read/write). It runs a one-outstanding-transaction valid/ready protocol on all three sides and buffers the accepted request and the returned data. Addresses below the memory base get a local response and never reach memory. It sits between the fetch/LSU stages and the memory wrapper that calls pmem_read/pmem_write.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MASK_W, 8, write byte-mask width (matches pmem mask argument)
MBASE, 32'h8000_0000, lowest valid memory address

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous reset, active-low
if_req_valid  in  1  fetch read request
if_req_ready  out  1  fetch request accepted this cycle
if_addr  in  ADDR_W  fetch address
if_rsp_valid  out  1  fetch data valid
if_rsp_ready  in  1  fetch takes data
if_rdata  out  DATA_W  fetch data
ls_req_valid  in  1  load/store request
ls_req_ready  out  1  load/store request accepted
ls_addr  in  ADDR_W  load/store address
ls_wen  in  1  1 = write
ls_wdata  in  DATA_W  write data
ls_wmask  in  MASK_W  write byte mask
ls_rsp_valid  out  1  load/store response valid (reads and writes)
ls_rsp_ready  in  1  load/store takes response
ls_rdata  out  DATA_W  load data; 0 for writes
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_W  registered address
mem_wen  out  1  registered write enable
mem_wdata  out  DATA_W  registered write data
mem_wmask  out  MASK_W  registered mask; 0 for reads
mem_rsp_valid  in  1  memory response
mem_rsp_ready  out  1  arbiter accepts response
mem_rdata  in  DATA_W  memory read data

Behaviour:
- FSM states: IDLE, MREQ, MRSP, DELIVER.
- Reset (async, rst_n=0): state=IDLE, owner=none. All valid/ready outputs are 0. mem_addr/wdata/wmask/wen, if_rdata and ls_rdata are 0. Reset mid-transaction abandons it; memory is reset by the same rst_n.
- IDLE: grant is combinational. Default policy is fixed priority: LSU wins over fetch when both are valid. Only the granted requester sees req_ready=1. On the accepting edge (valid&&ready), latch addr/wen/wdata/wmask and the owner.
- After acceptance: if latched addr < MBASE (unsigned compare), go to DELIVER with rdata=0 (local response, 1-cycle latency, no memory access). Otherwise go to MREQ.
- MREQ: mem_req_valid=1, with payload held stable. On mem_req_ready go to MRSP.
- MRSP: mem_rsp_ready=1. On mem_rsp_valid, capture mem_rdata (forced to 0 if write) and go to DELIVER.
- DELIVER: the owner's rsp_valid=1 with rdata held stable. On owner rsp_ready go to IDLE; no new request is accepted in the same cycle.
- Minimum round trip for an in-range access with zero-wait memory: accept at cycle 0, then MREQ at 1, MRSP at 2, DELIVER at 3, IDLE at 4.
- Requesters must hold valid/payload until ready; a drop before ready is legal and simply not granted.
- Only one transaction is outstanding at a time. The non-owner's req_ready stays 0 until IDLE.
- A mem_rsp_valid arriving outside MRSP is ignored (mem_rsp_ready=0).

Optional Feature:
Macro ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit last_owner register (reset = fetch). When both requesters are valid in IDLE, grant goes to the one that did not own the last transaction. A single valid requester is always granted.
- Undefined: fixed LSU priority; last_owner register is absent.

Decomposition:
- Shared defines file: MBASE, state encodings (IDLE=2'd0, MREQ=2'd1, MRSP=2'd2, DELIVER=2'd3), owner encoding (OWN_IF=1'b0, OWN_LS=1'b1).
- One natural sub-module: ysyx_23060201_arb_grant. It is the combinational grant logic including the optional round-robin pointer input. The FSM and buffers stay in the top.

Test Plan:
- Reset: hold rst_n=0, toggle clk, then release -> all valid/ready outputs 0, state IDLE; assert rst_n=0 during MRSP -> outputs return to 0 asynchronously, with no stale rsp_valid after release.
- Fetch read, addr 0x8000_0000, memory returns 0x0000_0413 with zero wait -> if_rsp_valid at cycle 3 after accept, if_rdata=0x0000_0413, ls_rsp_valid stays 0.
- Simultaneous if/ls valid, ls write addr 0x8000_0010, wdata 0xDEADBEEF, mask 8'b1111 -> ls granted first, mem_wen=1, ls_rdata=0; fetch granted only after ls_rsp handshake.
- Fetch addr 0x0000_0100 (< MBASE) -> mem_req_valid never asserted, if_rsp_valid next cycle after accept with if_rdata=0.
- Backpressure: mem_req_ready low 5 cycles, mem_rsp_valid delayed 3 cycles, if_rsp_ready low 2 cycles -> mem payload and if_rdata stable throughout, with exactly one handshake on each channel.
- With ARB_ROUND_ROBIN_EN, both requesters continuously valid -> grants alternate LS, IF, LS, IF; without the macro -> LS every time.
